fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 31 +++
 rtl/fetch_ctrl_if.sv | 46 ++++
 rtl/fetch_fifo2.sv | 65 ++++++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types for the instruction fetch controller: data and
//                address widths, the FIFO entry struct and the FSM state
//                encoding. The FAULT state is only reachable when the
//                FETCH_BOUNDS_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int c_instr_w = 32;
    localparam int c_addr_w  = 32;

    typedef logic [c_instr_w-1:0] instr_t;
    typedef logic [c_addr_w-1:0]  addr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Program-memory and decode-side bundle of the fetch
//                controller. master = fetch_ctrl, slave = memory/decode side.
//                Signals: pc_out, instr_in, redirect_valid, redirect_pc, halt,
//                inst_valid, inst_ready, inst_data, inst_pc and, with macro
//                FETCH_BOUNDS_EN, fault.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    addr_t  pc_out;
    instr_t instr_in;
    logic   redirect_valid;
    addr_t  redirect_pc;
    logic   halt;
    logic   inst_valid;
    logic   inst_ready;
    instr_t inst_data;
    addr_t  inst_pc;
`ifdef FETCH_BOUNDS_EN
    logic   fault;

    modport master (
        output pc_out, inst_valid, inst_data, inst_pc, fault,
        input  instr_in, redirect_valid, redirect_pc, halt, inst_ready
    );
    modport slave (
        input  pc_out, inst_valid, inst_data, inst_pc, fault,
        output instr_in, redirect_valid, redirect_pc, halt, inst_ready
    );
`else
    modport master (
        output pc_out, inst_valid, inst_data, inst_pc,
        input  instr_in, redirect_valid, redirect_pc, halt, inst_ready
    );
    modport slave (
        input  pc_out, inst_valid, inst_data, inst_pc,
        output instr_in, redirect_valid, redirect_pc, halt, inst_ready
    );
`endif

endinterface
`default_nettype wire

// File: rtl/fetch_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo2
//  Description : Two-entry {pc, instr} buffer between program memory and
//                decode. Ports: clk, rst, i_push, i_pop, i_flush, i_entry,
//                o_count, o_head. A push into a full buffer is only taken
//                when a pop happens in the same cycle. Flush empties the
//                buffer and wins over push. Not affected by FETCH_BOUNDS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo2
    import fetch_ctrl_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_push,
    input  wire logic         i_pop,
    input  wire logic         i_flush,
    input  wire fetch_entry_t i_entry,
    output logic [1:0]        o_count,
    output fetch_entry_t      o_head
);

    fetch_entry_t r_mem [2];
    logic         r_head_ptr;
    logic [1:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_tail_ptr;

    assign w_pop_ok  = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && !i_flush && ((r_count != 2'd2) || w_pop_ok);
    // With two slots the tail equals head when count is 0 or 2; a full push
    // with a pop therefore overwrites the slot being popped, which is correct.
    assign w_tail_ptr = r_head_ptr ^ r_count[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_head_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[w_tail_ptr] <= i_entry;
            end
            if (w_pop_ok) begin
                r_head_ptr <= ~r_head_ptr;
            end
            if (i_flush) begin
                r_count <= 2'd0;
            end else if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. Drives a word address to
//                program memory, captures the combinational read data into a
//                two-entry buffer and presents the head to decode with a
//                valid/ready handshake. Supports redirect (flush + new pc) and
//                halt. Ports: clk, rst, bus (fetch_ctrl_if.master).
//                Macro FETCH_BOUNDS_EN: out-of-range fetches raise a sticky
//                fault and park the FSM in FAULT; otherwise pc wraps modulo
//                MEM_DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int    MEM_DEPTH = 256,
    parameter addr_t RESET_PC  = 32'd0
)
(
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_ctrl_if.master bus
);

    localparam addr_t c_mem_depth = addr_t'(MEM_DEPTH);

    fetch_state_t r_state, w_state_nxt;
    addr_t        r_pc, w_pc_nxt, w_pc_inc;
    logic         w_push, w_pop, w_fetch_ok, w_in_range;
    logic [1:0]   w_count;
    fetch_entry_t w_head, w_entry;

`ifdef FETCH_BOUNDS_EN
    logic r_fault, w_fault_nxt;
    logic w_redir_in_range;

    assign w_in_range       = (r_pc < c_mem_depth);
    assign w_redir_in_range = (bus.redirect_pc < c_mem_depth);
    assign w_pc_inc         = r_pc + 32'd1;
    assign bus.fault        = r_fault;
`else
    assign w_in_range = 1'b1;
    assign w_pc_inc   = (r_pc >= c_mem_depth - 32'd1) ? '0 : r_pc + 32'd1;
`endif

    assign w_pop      = (w_count != 2'd0) && bus.inst_ready;
    // Room exists if not full, or if the head leaves this same cycle.
    assign w_fetch_ok = !bus.halt && ((w_count != 2'd2) || w_pop);
    assign w_entry    = '{pc: r_pc, instr: bus.instr_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_pc    <= RESET_PC;
`ifdef FETCH_BOUNDS_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
`ifdef FETCH_BOUNDS_EN
            r_fault <= w_fault_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
`ifdef FETCH_BOUNDS_EN
        w_fault_nxt = r_fault;
`endif
        case (r_state)
            // First cycle out of reset already fetches so the first
            // instruction is valid one cycle after rst falls.
            ST_RESET: begin
                w_state_nxt = ST_RUN;
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                end else if (w_fetch_ok && w_in_range) begin
                    w_push   = 1'b1;
                    w_pc_nxt = w_pc_inc;
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = bus.halt ? ST_HALTED : ST_RUN;
                end else if (bus.halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_fetch_ok) begin
`ifdef FETCH_BOUNDS_EN
                    if (w_in_range) begin
                        w_push   = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end else begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end
`else
                    w_push   = 1'b1;
                    w_pc_nxt = w_pc_inc;
`endif
                end
            end
            ST_HALTED: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = bus.halt ? ST_HALTED : ST_RUN;
                end else if (!bus.halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
`ifdef FETCH_BOUNDS_EN
            // Buffer keeps draining; only an in-range redirect leaves.
            ST_FAULT: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (w_redir_in_range) begin
                        w_fault_nxt = 1'b0;
                        w_state_nxt = bus.halt ? ST_HALTED : ST_RUN;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    fetch_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_entry (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.pc_out     = r_pc;
    assign bus.inst_valid = (w_count != 2'd0);
    assign bus.inst_data  = w_head.instr;
    assign bus.inst_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed self-checking bench for fetch_ctrl. Program memory
//                is a combinational function of pc_out. Checks follow
//                FETCH_BOUNDS_EN when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .MEM_DEPTH (256),
        .RESET_PC  (32'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[7:0], 8'h5A, ~a[7:0]};
    endfunction

    assign bus.instr_in = mem_word(bus.pc_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
`ifdef FETCH_BOUNDS_EN
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
`endif

        // Streaming from reset: one instruction per cycle starting at 0
        rst            = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("stream_pc", bus.inst_pc, 32'(i));
            check("stream_data", bus.inst_data, mem_word(32'(i)));
        end
        check("stream_pc_out", bus.pc_out, 32'd8);

        // Backpressure: buffer fills, pc_out holds, head stays stable
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("bp_inst_pc", bus.inst_pc, 32'd7);
            check("bp_inst_data", bus.inst_data, mem_word(32'd7));
            check("bp_pc_out", bus.pc_out, 32'd9);
        end
        bus.inst_ready = 1'b1;
        for (int i = 8; i < 11; i++) begin
            tick();
            check("release_pc", bus.inst_pc, 32'(i));
            check("release_data", bus.inst_data, mem_word(32'(i)));
        end

        // Redirect while full with a pop in the same cycle
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        tick();
        bus.redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("redir_pc_out", bus.pc_out, 32'd40);
        tick();
        check("redir_first_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("redir_first_pc", bus.inst_pc, 32'd40);
        check("redir_first_data", bus.inst_data, mem_word(32'd40));
        tick();
        check("redir_second_pc", bus.inst_pc, 32'd41);

        // Halt: buffer drains, pc_out frozen at 42
        bus.halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
            check("halt_pc_out", bus.pc_out, 32'd42);
        end
        bus.halt = 1'b0;
        tick();
        tick();
        check("resume_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("resume_pc", bus.inst_pc, 32'd42);
        tick();
        check("resume_next_pc", bus.inst_pc, 32'd43);

        // Top of memory
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd254;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("top_254", bus.inst_pc, 32'd254);
        tick();
        check("top_255", bus.inst_pc, 32'd255);
`ifdef FETCH_BOUNDS_EN
        tick();
        check("fault_set", {31'd0, bus.fault}, 32'd1);
        check("fault_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        check("fault_sticky", {31'd0, bus.fault}, 32'd1);
        check("fault_no_fetch", {31'd0, bus.inst_valid}, 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd10;
        tick();
        bus.redirect_valid = 1'b0;
        check("fault_clear", {31'd0, bus.fault}, 32'd0);
        tick();
        check("fault_exit_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("fault_exit_pc", bus.inst_pc, 32'd10);
        tick();
        check("fault_exit_next", bus.inst_pc, 32'd11);
`else
        check("wrap_pc_out", bus.pc_out, 32'd0);
        tick();
        check("wrap_0", bus.inst_pc, 32'd0);
        check("wrap_0_data", bus.inst_data, mem_word(32'd0));
        tick();
        check("wrap_1", bus.inst_pc, 32'd1);
`endif

        // Reset mid-stream with full buffer and a simultaneous redirect
        bus.inst_ready = 1'b0;
        tick();
        check("prerst_valid", {31'd0, bus.inst_valid}, 32'd1);
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd77;
        bus.inst_ready     = 1'b1;
        tick();
        check("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("midrst_pc_out", bus.pc_out, 32'd0);
        check("midrst_inst_pc", bus.inst_pc, 32'd0);
        check("midrst_inst_data", bus.inst_data, 32'd0);
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        check("postrst_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("postrst_pc", bus.inst_pc, 32'd0);
        tick();
        check("postrst_next", bus.inst_pc, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
